snn_event_capture: RTL

Upstream stage of the convolution core. Pops raw spike words from the input event FIFO, decodes them into (x, y) coordinates and drives the capture side of the SNN event interface: event_coord, event_valid, event_ready, event_ack. Timestep markers embedded in the FIFO stream are consumed here and signalled separately. Out-of-bounds spikes are also consumed here, dropped and counted.

---
 rtl/snn_event_capture.sv | 128 ++++++++++++
 1 files changed

// File: rtl/snn_event_capture.sv
// snn_event_capture
// Upstream stage of the convolution core. Pops raw spike words from the input
// event FIFO, decodes them into (x, y) and presents them on the capture side
// of the event interface. Timestep markers are consumed and signalled with a
// one-cycle pulse. Out-of-range spikes are consumed, dropped and counted.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   enable           permits new FIFO reads; an event in flight always completes
//   fifo_empty       event FIFO empty flag
//   fifo_rd_en       FIFO read strobe (standard FIFO, data valid next cycle)
//   fifo_rd_data     raw word {marker, x, y}
//   event_coord      packed {x, y}, held between events
//   event_valid      event_coord is valid
//   event_ready      convolution accepts the event
//   event_ack        convolution finished the accepted event
//   timestep_done    one-cycle pulse per consumed timestep marker
//   drop_count       saturating count of out-of-range spikes
//   busy             high whenever the FSM is not idle
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for enable and a non-empty FIFO; issues the read
// FETCH    | FIFO data valid this cycle; decode marker / range / event
// SEND     | event_valid high, coord held until event_ready
// WAIT_ACK | event accepted, waiting for event_ack before the next read
module snn_event_capture #(
    parameter int COORD_WIDTH     = 8,
    parameter int IMG_WIDTH       = 32,
    parameter int IMG_HEIGHT      = 32,
    parameter int FIFO_DATA_WIDTH = 2*COORD_WIDTH+1,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
    output logic [2*COORD_WIDTH-1:0]   event_coord,
    output logic                       event_valid,
    input  logic                       event_ready,
    input  logic                       event_ack,
    output logic                       timestep_done,
    output logic [DROP_CNT_WIDTH-1:0]  drop_count,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT_ACK
    } state_t;

    // Limits carried one bit wider than a coordinate so the compare stays
    // correct even when the image dimension equals 2**COORD_WIDTH.
    localparam logic [COORD_WIDTH:0] X_LIM = (COORD_WIDTH+1)'(IMG_WIDTH);
    localparam logic [COORD_WIDTH:0] Y_LIM = (COORD_WIDTH+1)'(IMG_HEIGHT);

    state_t state_q;
    state_t state_d;

    logic                   word_marker;
    logic [COORD_WIDTH-1:0] word_x;
    logic [COORD_WIDTH-1:0] word_y;
    logic                   word_in_range;

    assign word_marker   = fifo_rd_data[FIFO_DATA_WIDTH-1];
    assign word_x        = fifo_rd_data[2*COORD_WIDTH-1:COORD_WIDTH];
    assign word_y        = fifo_rd_data[COORD_WIDTH-1:0];
    assign word_in_range = ({1'b0, word_x} < X_LIM) && ({1'b0, word_y} < Y_LIM);

    assign event_valid = (state_q == SEND);
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (word_marker || !word_in_range) begin
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // ack only counts on the handshake cycle itself
                if (event_ready) begin
                    state_d = event_ack ? IDLE : WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (event_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            event_coord   <= '0;
            timestep_done <= 1'b0;
            drop_count    <= '0;
        end else begin
            state_q       <= state_d;
            timestep_done <= (state_q == FETCH) && word_marker;
            if ((state_q == FETCH) && !word_marker) begin
                if (word_in_range) begin
                    event_coord <= {word_x, word_y};
                end else if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
